// File: rtl/vending_machine_n.sv
// Parameterised N-item vending machine: coin credit, vend handshake and greedy change return.
// Define VM_STOCK_EN to build per-item stock counters with restock; otherwise stock is unlimited.
module vending_machine_n #(
    parameter int NUM_ITEMS  = 4,
    parameter int NUM_COINS  = 4,
    parameter int CREDIT_W   = 7,
    parameter int MAX_CREDIT = 99,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICE = {7'd11, 7'd8, 7'd5, 7'd4},
    parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUE = {7'd50, 7'd10, 7'd5, 7'd1},
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_COINS-1:0]         coin_in,
    input  logic [NUM_ITEMS-1:0]         buy,
    input  logic                         refund,
    input  logic                         restock,
    output logic                         dispense_valid,
    output logic [$clog2(NUM_ITEMS)-1:0] dispense_item,
    input  logic                         dispense_ready,
    output logic                         change_valid,
    output logic [$clog2(NUM_COINS)-1:0] change_coin,
    input  logic                         change_ready,
    output logic [CREDIT_W-1:0]          credit,
    output logic [NUM_ITEMS-1:0]         avail,
    output logic [NUM_ITEMS-1:0]         sold_out,
    output logic                         busy,
    output logic                         buy_ok,
    output logic                         buy_fail,
    output logic                         coin_reject
);

    localparam int IW = $clog2(NUM_ITEMS);
    localparam int CW = $clog2(NUM_COINS);
    localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        IDLE,
        VEND,
        CHANGE
    } state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [IW-1:0]       item_q, item_d;
    logic                buy_ok_q, buy_ok_d;
    logic                buy_fail_q, buy_fail_d;
    logic                coin_reject_q, coin_reject_d;

    logic [IW-1:0]       sel_item;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic [CW-1:0]       chg_idx;
    logic [CREDIT_W-1:0] chg_val;
    logic [NUM_ITEMS-1:0] stock_nz;

    function automatic logic [CREDIT_W-1:0] price_of(input int i);
        return ITEM_PRICE[i*CREDIT_W +: CREDIT_W];
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_of(input int i);
        return COIN_VALUE[i*CREDIT_W +: CREDIT_W];
    endfunction

    // Descending scan so the lowest set buy bit is the one left standing.
    always_comb begin
        sel_item = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (buy[i]) sel_item = IW'(i);
        end
    end

    assign sel_price = price_of(int'(sel_item));

    always_comb begin
        coin_val = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin_in[i]) coin_val = coin_of(i);
        end
    end

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_ok  = (state_q == IDLE) && !refund && $onehot(coin_in) && (coin_sum <= MAX_SUM);

    // Coin values ascend, so the last one that fits is the largest coin not exceeding credit.
    always_comb begin
        chg_idx = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin_of(i) <= credit_q) chg_idx = CW'(i);
        end
    end

    assign chg_val = coin_of(int'(chg_idx));

`ifdef VM_STOCK_EN
    localparam logic [STOCK_W-1:0] STOCK_RELOAD = STOCK_W'(STOCK_INIT);

    logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q, stock_d;

    // Restock is applied last so it overrides a decrement landing on the same edge.
    always_comb begin
        stock_d = stock_q;
        if (state_q == VEND && dispense_ready) begin
            stock_d[item_q] = stock_q[item_q] - STOCK_W'(1);
        end
        if (restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_RELOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_RELOAD;
        end else begin
            stock_q <= stock_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_nz[i] = (stock_q[i] != '0);
            sold_out[i] = (stock_q[i] == '0);
        end
    end
`else
    logic unused_restock;

    assign unused_restock = restock;
    assign stock_nz       = '1;
    assign sold_out       = '0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            avail[i] = (state_q == IDLE) && (credit_q >= price_of(i)) && stock_nz[i];
        end
    end

    // A coin is accepted independently of the buy outcome; only a successful buy debits credit.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        item_d        = item_q;
        buy_ok_d      = 1'b0;
        buy_fail_d    = 1'b0;
        coin_reject_d = (coin_in != '0) && !coin_ok;

        unique case (state_q)
            IDLE: begin
                if (coin_ok) credit_d = credit_q + coin_val;
                if (refund) begin
                    if (credit_q != '0) state_d = CHANGE;
                end else if (buy != '0) begin
                    if (credit_q >= sel_price && stock_nz[sel_item]) begin
                        buy_ok_d = 1'b1;
                        item_d   = sel_item;
                        state_d  = VEND;
                        credit_d = credit_q - sel_price + (coin_ok ? coin_val : '0);
                    end else begin
                        buy_fail_d = 1'b1;
                    end
                end
            end
            VEND: begin
                if (dispense_ready) state_d = IDLE;
            end
            CHANGE: begin
                if (change_ready) begin
                    credit_d = credit_q - chg_val;
                    if (credit_q == chg_val) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            item_q        <= '0;
            buy_ok_q      <= 1'b0;
            buy_fail_q    <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            item_q        <= item_d;
            buy_ok_q      <= buy_ok_d;
            buy_fail_q    <= buy_fail_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign dispense_valid = (state_q == VEND);
    assign dispense_item  = item_q;
    assign change_valid   = (state_q == CHANGE);
    assign change_coin    = change_valid ? chg_idx : '0;
    assign credit         = credit_q;
    assign busy           = (state_q != IDLE);
    assign buy_ok         = buy_ok_q;
    assign buy_fail       = buy_fail_q;
    assign coin_reject    = coin_reject_q;

endmodule

// File: tb/tb_vending_machine_n.sv
// Testbench for vending_machine_n: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_vending_machine_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] coin_in = '0;
    logic [3:0] buy = '0;
    logic       refund = 1'b0;
    logic       restock = 1'b0;
    logic       dispense_ready = 1'b0;
    logic       change_ready = 1'b0;
    logic       dispense_valid;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [1:0] change_coin;
    logic [6:0] credit;
    logic [3:0] avail;
    logic [3:0] sold_out;
    logic       busy;
    logic       buy_ok;
    logic       buy_fail;
    logic       coin_reject;

    int nCompared = 0;
    int nMismatched = 0;

    vending_machine_n dut (
        .clk            (clk),
        .reset          (reset),
        .coin_in        (coin_in),
        .buy            (buy),
        .refund         (refund),
        .restock        (restock),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .dispense_ready (dispense_ready),
        .change_valid   (change_valid),
        .change_coin    (change_coin),
        .change_ready   (change_ready),
        .credit         (credit),
        .avail          (avail),
        .sold_out       (sold_out),
        .busy           (busy),
        .buy_ok         (buy_ok),
        .buy_fail       (buy_fail),
        .coin_reject    (coin_reject)
    );

    always #5 clk = ~clk;

    // Product prices and coin values as a customer would read them off the machine.
    function automatic int priceOf(input int i);
        case (i)
            0:       return 4;
            1:       return 5;
            2:       return 8;
            default: return 11;
        endcase
    endfunction

    function automatic int coinValue(input int i);
        case (i)
            0:       return 1;
            1:       return 5;
            2:       return 10;
            default: return 50;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] b, input bit rf,
                                 input bit rs, input bit dr, input bit cr);
        @(negedge clk);
        coin_in        = c;
        buy            = b;
        refund         = rf;
        restock        = rs;
        dispense_ready = dr;
        change_ready   = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        coin_in        = '0;
        buy            = '0;
        refund         = 1'b0;
        restock        = 1'b0;
        dispense_ready = 1'b0;
        change_ready   = 1'b0;
    endtask

    // Reference model: a pending product, or a precomputed queue of change coins.
    int m_credit;
    int m_vend;
    int m_chg[$];
    bit m_ok, m_fail, m_rej;
`ifdef VM_STOCK_EN
    int m_stock[4];
`endif

    function automatic bit stockOk(input int i);
`ifdef VM_STOCK_EN
        return m_stock[i] > 0;
`else
        return (i >= 0);
`endif
    endfunction

    function automatic int modelSoldOut();
        int s = 0;
`ifdef VM_STOCK_EN
        for (int i = 0; i < 4; i++) if (m_stock[i] == 0) s |= (1 << i);
`endif
        return s;
    endfunction

    task automatic modelReset();
        m_credit = 0;
        m_vend   = -1;
        m_chg.delete();
        m_ok     = 0;
        m_fail   = 0;
        m_rej    = 0;
`ifdef VM_STOCK_EN
        for (int i = 0; i < 4; i++) m_stock[i] = 2;
`endif
    endtask

    task automatic modelStep(input logic [3:0] c, input logic [3:0] b, input bit rf,
                             input bit rs, input bit dr, input bit cr);
        int nc;
        int cv;
        int idx;
        int rem;
        int k;
        bit good;
        m_ok   = 0;
        m_fail = 0;
        nc     = $countones(c);
        if (m_vend < 0 && m_chg.size() == 0) begin
            cv = 0;
            for (int i = 0; i < 4; i++) if (c[i]) cv = coinValue(i);
            good  = !rf && nc == 1 && (m_credit + cv <= 99);
            m_rej = (nc != 0) && !good;
            if (rf) begin
                rem = m_credit;
                while (rem > 0) begin
                    k = 3;
                    while (coinValue(k) > rem) k--;
                    m_chg.push_back(k);
                    rem -= coinValue(k);
                end
            end else if (b != 0) begin
                idx = -1;
                for (int i = 0; i < 4; i++) if (b[i] && idx < 0) idx = i;
                if (m_credit >= priceOf(idx) && stockOk(idx)) begin
                    m_ok     = 1;
                    m_vend   = idx;
                    m_credit -= priceOf(idx);
                end else begin
                    m_fail = 1;
                end
            end
            if (good) m_credit += cv;
        end else begin
            m_rej = (nc != 0);
            if (m_vend >= 0) begin
                if (dr) begin
`ifdef VM_STOCK_EN
                    m_stock[m_vend]--;
`endif
                    m_vend = -1;
                end
            end else if (cr) begin
                m_credit -= coinValue(m_chg[0]);
                void'(m_chg.pop_front());
            end
        end
`ifdef VM_STOCK_EN
        if (rs) for (int i = 0; i < 4; i++) m_stock[i] = 2;
`else
        if (rs) m_rej = m_rej;
`endif
    endtask

    task automatic checkModel(input int cyc);
        bit idle;
        int expAvail;
        idle = (m_vend < 0) && (m_chg.size() == 0);
        expAvail = 0;
        for (int i = 0; i < 4; i++) begin
            if (idle && m_credit >= priceOf(i) && stockOk(i)) expAvail |= (1 << i);
        end
        checkOutput($sformatf("rnd%0d_credit", cyc), int'(credit), m_credit);
        checkOutput($sformatf("rnd%0d_busy", cyc), int'(busy), int'(!idle));
        checkOutput($sformatf("rnd%0d_dv", cyc), int'(dispense_valid), int'(m_vend >= 0));
        checkOutput($sformatf("rnd%0d_cv", cyc), int'(change_valid), int'(m_chg.size() != 0));
        checkOutput($sformatf("rnd%0d_ok", cyc), int'(buy_ok), int'(m_ok));
        checkOutput($sformatf("rnd%0d_fail", cyc), int'(buy_fail), int'(m_fail));
        checkOutput($sformatf("rnd%0d_rej", cyc), int'(coin_reject), int'(m_rej));
        checkOutput($sformatf("rnd%0d_avail", cyc), int'(avail), expAvail);
        checkOutput($sformatf("rnd%0d_sold", cyc), int'(sold_out), modelSoldOut());
        if (m_vend >= 0) checkOutput($sformatf("rnd%0d_item", cyc), int'(dispense_item), m_vend);
        if (m_chg.size() != 0) checkOutput($sformatf("rnd%0d_coin", cyc), int'(change_coin), m_chg[0]);
    endtask

    task automatic doReset();
        @(negedge clk);
        clearInputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    typedef struct {
        logic [3:0] coin;
        logic [3:0] buy;
        int refund, dready, cready;
        int credit, busy, dv, ditem, cv, ccoin, ok, fail, rej;
    } vec_t;

    function automatic vec_t mk(input int c, input int b, input int rf, input int dr, input int cr,
                                input int cred, input int bz, input int dv, input int di,
                                input int cv, input int cc, input int ok, input int fl, input int rj);
        vec_t v;
        v.coin = 4'(c);
        v.buy = 4'(b);
        v.refund = rf;
        v.dready = dr;
        v.cready = cr;
        v.credit = cred;
        v.busy = bz;
        v.dv = dv;
        v.ditem = di;
        v.cv = cv;
        v.ccoin = cc;
        v.ok = ok;
        v.fail = fl;
        v.rej = rj;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int expA;
        logic [3:0] rc, rb;
        bit rrf, rrs, rdr, rcr;

        //           coin    buy     rf dr cr  cred bz dv it cv cc ok fl rj
        vecs.push_back(mk('b0100, 'b0000, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0001, 'b0000, 0, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b1000, 0, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0));
        vecs.push_back(mk('b0000, 'b0000, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0010, 'b0000, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b0100, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk('b0010, 'b0000, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0010, 'b0000, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0001, 'b0000, 0, 0, 0, 16, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0001, 'b0000, 0, 0, 0, 17, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b0000, 1, 0, 0, 17, 1, 0, 0, 1, 2, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b0000, 0, 0, 1, 7, 1, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b0000, 0, 0, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b0000, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b1000, 'b0000, 0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0100, 'b0000, 0, 0, 0, 60, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0100, 'b0000, 0, 0, 0, 70, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0100, 'b0000, 0, 0, 0, 80, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0100, 'b0000, 0, 0, 0, 90, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0010, 'b0000, 0, 0, 0, 95, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0100, 'b0000, 0, 0, 0, 95, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk('b0011, 'b0000, 0, 0, 0, 95, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk('b0001, 'b0000, 0, 0, 0, 96, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b0001, 0, 0, 0, 92, 1, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk('b0001, 'b0000, 0, 0, 0, 92, 1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk('b0000, 'b0001, 0, 0, 0, 92, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0000, 'b0000, 0, 1, 0, 92, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0010, 'b0110, 0, 0, 0, 92, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk('b0000, 'b0000, 0, 1, 0, 92, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk('b0001, 'b0000, 1, 0, 0, 92, 1, 0, 0, 1, 3, 0, 0, 1));
        vecs.push_back(mk('b0000, 'b0000, 0, 0, 1, 42, 1, 0, 0, 1, 2, 0, 0, 0));

        // Reset state, sampled while reset is still asserted.
        #12;
        checkOutput("rst_credit", int'(credit), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_dv", int'(dispense_valid), 0);
        checkOutput("rst_cv", int'(change_valid), 0);
        checkOutput("rst_pulses", int'({buy_ok, buy_fail, coin_reject}), 0);
        checkOutput("rst_avail", int'(avail), 0);
        checkOutput("rst_sold", int'(sold_out), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].coin, vecs[i].buy, vecs[i].refund != 0, 1'b0,
                          vecs[i].dready != 0, vecs[i].cready != 0);
            checkOutput($sformatf("tbl%0d_credit", i), int'(credit), vecs[i].credit);
            checkOutput($sformatf("tbl%0d_busy", i), int'(busy), vecs[i].busy);
            checkOutput($sformatf("tbl%0d_dv", i), int'(dispense_valid), vecs[i].dv);
            checkOutput($sformatf("tbl%0d_cv", i), int'(change_valid), vecs[i].cv);
            checkOutput($sformatf("tbl%0d_ok", i), int'(buy_ok), vecs[i].ok);
            checkOutput($sformatf("tbl%0d_fail", i), int'(buy_fail), vecs[i].fail);
            checkOutput($sformatf("tbl%0d_rej", i), int'(coin_reject), vecs[i].rej);
            if (vecs[i].dv != 0) checkOutput($sformatf("tbl%0d_item", i), int'(dispense_item), vecs[i].ditem);
            if (vecs[i].cv != 0) checkOutput($sformatf("tbl%0d_coin", i), int'(change_coin), vecs[i].ccoin);
            expA = 0;
            for (int k = 0; k < 4; k++) begin
                if (vecs[i].busy == 0 && vecs[i].credit >= priceOf(k)) expA |= (1 << k);
            end
            checkOutput($sformatf("tbl%0d_avail", i), int'(avail), expA);
        end

        // Asynchronous reset in the middle of a change return.
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("chgrst_pre_cv", int'(change_valid), 1);
        checkOutput("chgrst_pre_credit", int'(credit), 6);
        @(negedge clk);
        clearInputs();
        #2 reset = 1'b1;
        #1;
        checkOutput("chgrst_cv", int'(change_valid), 0);
        checkOutput("chgrst_credit", int'(credit), 0);
        checkOutput("chgrst_busy", int'(busy), 0);
        checkOutput("chgrst_coin", int'(change_coin), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("chgrst_post%0d_cv", i), int'(change_valid), 0);
            checkOutput($sformatf("chgrst_post%0d_credit", i), int'(credit), 0);
        end

        // Asynchronous reset while a product is waiting for its handshake.
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("vendrst_pre_dv", int'(dispense_valid), 1);
        @(negedge clk);
        clearInputs();
        #2 reset = 1'b1;
        #1;
        checkOutput("vendrst_dv", int'(dispense_valid), 0);
        checkOutput("vendrst_credit", int'(credit), 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("vendrst_post_dv", int'(dispense_valid), 0);

        // Stock exhaustion and restock.
        doReset();
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("stk_buy%0d_ok", i), int'(buy_ok), 1);
            applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("stk_credit", int'(credit), 4);
`ifdef VM_STOCK_EN
        checkOutput("stk_sold0", int'(sold_out[0]), 1);
        checkOutput("stk_avail0", int'(avail[0]), 0);
        applyStimulus(4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stk_buy2_fail", int'(buy_fail), 1);
        checkOutput("stk_buy2_dv", int'(dispense_valid), 0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stk_restock_sold0", int'(sold_out[0]), 0);
        checkOutput("stk_restock_avail0", int'(avail[0]), 1);
`else
        checkOutput("stk_sold", int'(sold_out), 0);
        checkOutput("stk_avail0", int'(avail[0]), 1);
        applyStimulus(4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stk_buy2_ok", int'(buy_ok), 1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("stk_restock_sold", int'(sold_out), 0);
`endif

        // Randomized traffic against the reference model.
        doReset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rc = 4'b0000;
                8, 9:       rc = 4'($urandom_range(0, 15));
                default:    rc = 4'(1 << $urandom_range(0, 3));
            endcase
            rb  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rrf = ($urandom_range(0, 15) == 0);
            rrs = ($urandom_range(0, 19) == 0);
            rdr = ($urandom_range(0, 1) == 1);
            rcr = ($urandom_range(0, 1) == 1);
            applyStimulus(rc, rb, rrf, rrs, rdr, rcr);
            modelStep(rc, rb, rrf, rrs, rdr, rcr);
            checkModel(cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/vending_machine_n.md
VENDING_MACHINE_N -- requirements
Module: vending_machine_n

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 4: number of products.
REQ-002 SHALL have parameter NUM_COINS, default 4: number of coin denominations.
REQ-003 SHALL have parameter CREDIT_W, default 7: credit width, in units of 100 won.
REQ-004 SHALL have parameter MAX_CREDIT, default 99: credit ceiling.
REQ-005 SHALL have parameter ITEM_PRICE, default {11,8,5,4}: packed prices; item i at [i*CREDIT_W +: CREDIT_W].
REQ-006 SHALL have parameter COIN_VALUE, default {50,10,5,1}: packed coin values in the same layout; coin 0 = 1; values strictly ascending.
REQ-007 SHALL have parameter STOCK_W, default 4, and STOCK_INIT, default 2: stock counter width and reload value.
REQ-008 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-009 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-010 SHALL have ports coin_in  input  NUM_COINS  one-cycle coin pulses; buy  input  NUM_ITEMS  one-cycle buy pulses; refund  input  1  one-cycle pulse; restock  input  1  one-cycle pulse.
REQ-011 SHALL have ports dispense_valid  output  1; dispense_item  output  $clog2(NUM_ITEMS); dispense_ready  input  1: product handshake.
REQ-012 SHALL have ports change_valid  output  1; change_coin  output  $clog2(NUM_COINS); change_ready  input  1: change handshake.
REQ-013 SHALL have outputs credit  CREDIT_W; avail  NUM_ITEMS; sold_out  NUM_ITEMS; busy  1; buy_ok  1 (pulse); buy_fail  1 (pulse); coin_reject  1 (pulse).

Function
REQ-014 SHALL implement states IDLE, VEND, CHANGE; busy = (state != IDLE).
REQ-015 In IDLE, priority SHALL be refund > buy > coin. Refund with credit != 0 moves to CHANGE; refund with credit 0 is ignored.
REQ-016 A buy SHALL select the lowest set bit. It succeeds iff credit (pre-cycle value) >= price and stock > 0. Success: credit -= price, buy_ok pulse, next cycle VEND with dispense_valid=1. Failure: buy_fail pulse, credit unchanged.
REQ-017 A coin SHALL be accepted only in IDLE, with no refund that cycle, exactly one coin_in bit set, and credit+value <= MAX_CREDIT. Otherwise coin_reject pulses for one cycle and credit is unchanged.
REQ-018 A coin and a successful buy in the same cycle SHALL give credit_next = credit - price + value, with the ceiling checked on credit+value.
REQ-019 In VEND, dispense_valid and dispense_item SHALL hold stable until dispense_ready=1. In that cycle stock[item] decrements and the state returns to IDLE.
REQ-020 In CHANGE, change_coin SHALL be the largest coin with value <= credit, recomputed each cycle. On change_ready, credit -= value. When credit reaches 0 the state returns to IDLE on the same edge, so change_valid drops the next cycle.
REQ-021 buy, coin_in, and refund SHALL be ignored in VEND and CHANGE; coins there raise coin_reject.
REQ-022 avail[i] SHALL equal (state==IDLE) & credit>=price[i] & stock[i]>0, combinationally from registers.
REQ-023 restock SHALL reload every stock counter to STOCK_INIT in any state. If it coincides with a VEND decrement, the reload wins.
REQ-024 sold_out[i] SHALL equal (stock[i]==0).
REQ-025 buy_ok, buy_fail, and coin_reject SHALL be registered one-cycle pulses, asserted the cycle after the causing input.

Reset
REQ-026 reset SHALL asynchronously force state IDLE, credit 0, all stock to STOCK_INIT, and every output 0 except avail and sold_out, which follow REQ-022/REQ-024.
REQ-027 Reset mid-VEND or mid-CHANGE SHALL abandon the transaction with no further dispense_valid or change_valid.

Configuration
REQ-028 With VM_STOCK_EN defined, stock counters SHALL exist per REQ-016/019/022/023/024.
REQ-029 Without VM_STOCK_EN, no stock registers SHALL exist: stock is treated as infinite, sold_out=0, restock is ignored, and buy fails only on insufficient credit.

Verification
REQ-030 coin_in=4'b0100, then 4'b0001 -> credit 11; buy=4'b1000 -> buy_ok, next cycle dispense_valid=1, dispense_item=3, credit 0; dispense_ready -> IDLE.
REQ-031 Credit 5, buy=4'b0100 -> buy_fail pulse, credit stays 5, no dispense_valid.
REQ-032 Credit 17, refund, change_ready held 1 -> change_coin 2,1,0,0 on 4 consecutive cycles, credit 0, busy drops.
REQ-033 Credit 95, coin_in=4'b0100 -> coin_reject, credit 95. coin_in=4'b0011 -> coin_reject, credit 95.
REQ-034 VM_STOCK_EN, credit 12, buy item0 twice (both handshaken) -> stock0=0, sold_out[0]=1. Third buy[0] -> buy_fail. restock -> sold_out[0]=0, avail[0]=1.
REQ-035 reset asserted mid-CHANGE with credit 6 -> outputs 0, credit 0, state IDLE immediately, no further change_valid after release.
